// File: rtl/ctrl_stage_pipe_if.sv
// ctrl_stage_pipe_if: Decode-to-pipeline control bundle bus with master (hazard/decode side) and slave (pipe) modports
//   d_valid_i/d_ctrl_i : bundle offered by Decode
//   stall_i/flush_i    : per-stage hazard requests, bit s = stage s
//   d_stall_o          : Decode/Fetch hold
//   valid_o/ctrl_o     : per-stage valid and bundle, stage s at ctrl_o[s*CW +: CW]
//   occ_o/drained_o    : count of valid stages, pipe empty flag
interface ctrl_stage_pipe_if #(
    parameter int CW   = 11,
    parameter int NSTG = 3,
    parameter int OCCW = $clog2(NSTG + 1)
);
    logic                 d_valid_i;
    logic [CW-1:0]        d_ctrl_i;
    logic [NSTG-1:0]      stall_i;
    logic [NSTG-1:0]      flush_i;
    logic                 d_stall_o;
    logic [NSTG-1:0]      valid_o;
    logic [NSTG*CW-1:0]   ctrl_o;
    logic [OCCW-1:0]      occ_o;
    logic                 drained_o;
    modport master(output d_valid_i, d_ctrl_i, stall_i, flush_i,
                   input  d_stall_o, valid_o, ctrl_o, occ_o, drained_o);
    modport slave (input  d_valid_i, d_ctrl_i, stall_i, flush_i,
                   output d_stall_o, valid_o, ctrl_o, occ_o, drained_o);
endinterface

// File: rtl/ctrl_stage_pipe.sv
// ctrl_stage_pipe: control-bundle pipeline from Decode through NSTG stages with stall, flush, bubble and per-stage field pruning
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : ctrl_stage_pipe_if slave (Decode bundle in, hazard requests in, per-stage valid/ctrl and status out)
module ctrl_stage_pipe #(
    parameter int                   CW        = 11,
    parameter int                   NSTG      = 3,
    parameter logic [NSTG*CW-1:0]   KEEP_MASK = {NSTG*CW{1'b1}},
    parameter int                   OCCW      = $clog2(NSTG + 1)
) (
    input logic               clk,
    input logic               rst,
    ctrl_stage_pipe_if.slave  bus
);
    logic [NSTG-1:0]    eff;
    logic [NSTG-1:0]    v;
    logic [NSTG*CW-1:0] c;
    logic [OCCW-1:0]    occ;

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        logic          in_v;
        logic [CW-1:0] in_c;
        logic          vr;
        logic [CW-1:0] cr;
        // a stall freezes this stage and every younger (lower-index) one
        assign eff[s] = |bus.stall_i[NSTG-1:s];
        if (s == 0) begin : g_head
            assign in_v = bus.d_valid_i;
            assign in_c = bus.d_ctrl_i;
        end else begin : g_body
            // a frozen predecessor hands over a bubble
            assign in_v = v[s-1] & ~eff[s-1];
            assign in_c = c[(s-1)*CW +: CW];
        end
        always_ff @(posedge clk)
            if (rst || bus.flush_i[s]) begin
                vr <= 1'b0;
                cr <= '0;
            end else if (!eff[s]) begin
                vr <= in_v;
                cr <= in_v ? in_c & KEEP_MASK[s*CW +: CW] : '0;
            end
        assign v[s]            = vr;
        assign c[s*CW +: CW]   = cr;
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < NSTG; i++)
            occ = occ + OCCW'(v[i]);
    end

    assign bus.d_stall_o = eff[0];
    assign bus.valid_o   = v;
    assign bus.ctrl_o    = c;
    assign bus.occ_o     = occ;
    assign bus.drained_o = (occ == '0);
endmodule

// File: tb/tb_ctrl_stage_pipe.sv
// tb_ctrl_stage_pipe: directed scoreboard bench for ctrl_stage_pipe with stage2 pruned to 11'h003
module tb_ctrl_stage_pipe;
    typedef struct {
        logic [2:0]  v;
        logic [10:0] c2, c1, c0;
        logic [1:0]  occ;
        logic        ds;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    ctrl_stage_pipe_if #(.CW(11), .NSTG(3)) bus();

    ctrl_stage_pipe #(
        .CW(11),
        .NSTG(3),
        .KEEP_MASK({11'h003, 11'h7FF, 11'h7FF})
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("valid",   32'(bus.valid_o),         32'(e.v));
            chk("ctrl0",   32'(bus.ctrl_o[10:0]),    32'(e.c0));
            chk("ctrl1",   32'(bus.ctrl_o[21:11]),   32'(e.c1));
            chk("ctrl2",   32'(bus.ctrl_o[32:22]),   32'(e.c2));
            chk("occ",     32'(bus.occ_o),           32'(e.occ));
            chk("drained", 32'(bus.drained_o),       32'(e.occ == 2'd0));
            chk("d_stall", 32'(bus.d_stall_o),       32'(e.ds));
        end

    task automatic step(input logic r, input logic dv, input logic [10:0] dc,
                        input logic [2:0] st, input logic [2:0] fl,
                        input logic [2:0] ev, input logic [10:0] e2, input logic [10:0] e1,
                        input logic [10:0] e0, input logic [1:0] eo, input logic eds);
        exp_t e;
        rst = r;
        bus.d_valid_i = dv;
        bus.d_ctrl_i  = dc;
        bus.stall_i   = st;
        bus.flush_i   = fl;
        @(posedge clk);
        e.v = ev; e.c2 = e2; e.c1 = e1; e.c0 = e0; e.occ = eo; e.ds = eds;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end");
        $fatal(1, "timeout");
    end

    initial begin
        bus.d_valid_i = 1'b0;
        bus.d_ctrl_i  = '0;
        bus.stall_i   = '0;
        bus.flush_i   = '0;
        @(negedge clk);
        // reset held with live Decode input
        step(1, 1, 11'h7FF, 3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 2'd0, 0);
        step(1, 1, 11'h7FF, 3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 2'd0, 0);
        // flow A, B, C
        step(0, 1, 11'h155, 3'b000, 3'b000, 3'b001, 11'h000, 11'h000, 11'h155, 2'd1, 0);
        step(0, 1, 11'h2AA, 3'b000, 3'b000, 3'b011, 11'h000, 11'h155, 11'h2AA, 2'd2, 0);
        step(0, 1, 11'h0F0, 3'b000, 3'b000, 3'b111, 11'h001, 11'h2AA, 11'h0F0, 2'd3, 0);
        // invalid Decode with junk bundle enters as clean bubble
        step(0, 0, 11'h7FF, 3'b000, 3'b000, 3'b110, 11'h002, 11'h0F0, 11'h000, 2'd2, 0);
        // Z, A, B then backward stall at stage1
        step(1, 1, 11'h7FF, 3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 2'd0, 0);
        step(0, 1, 11'h7FF, 3'b000, 3'b000, 3'b001, 11'h000, 11'h000, 11'h7FF, 2'd1, 0);
        step(0, 1, 11'h155, 3'b000, 3'b000, 3'b011, 11'h000, 11'h7FF, 11'h155, 2'd2, 0);
        step(0, 1, 11'h2AA, 3'b000, 3'b000, 3'b111, 11'h003, 11'h155, 11'h2AA, 2'd3, 0);
        step(0, 1, 11'h0F0, 3'b010, 3'b000, 3'b011, 11'h000, 11'h155, 11'h2AA, 2'd2, 1);
        step(0, 1, 11'h0F0, 3'b010, 3'b000, 3'b011, 11'h000, 11'h155, 11'h2AA, 2'd2, 1);
        step(0, 1, 11'h0F0, 3'b000, 3'b000, 3'b111, 11'h001, 11'h2AA, 11'h0F0, 2'd3, 0);
        // flush wins over stall at stage0, then held bubble
        step(0, 1, 11'h7FF, 3'b001, 3'b001, 3'b100, 11'h002, 11'h000, 11'h000, 2'd1, 1);
        step(0, 1, 11'h7FF, 3'b001, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 2'd0, 1);
        // mask: stage2 keeps only 11'h003
        step(0, 1, 11'h7FF, 3'b000, 3'b000, 3'b001, 11'h000, 11'h000, 11'h7FF, 2'd1, 0);
        step(0, 1, 11'h7FF, 3'b000, 3'b000, 3'b011, 11'h000, 11'h7FF, 11'h7FF, 2'd2, 0);
        step(0, 1, 11'h7FF, 3'b000, 3'b000, 3'b111, 11'h003, 11'h7FF, 11'h7FF, 2'd3, 0);
        // reset during stall, then flow resumes
        step(1, 1, 11'h7FF, 3'b100, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 2'd0, 1);
        step(0, 1, 11'h155, 3'b000, 3'b000, 3'b001, 11'h000, 11'h000, 11'h155, 2'd1, 0);
        step(0, 1, 11'h2AA, 3'b000, 3'b000, 3'b011, 11'h000, 11'h155, 11'h2AA, 2'd2, 0);
        // isolated middle flush, full stall, flush of stalled last stage, drain
        step(0, 1, 11'h0F0, 3'b000, 3'b010, 3'b101, 11'h001, 11'h000, 11'h0F0, 2'd2, 0);
        step(0, 1, 11'h7FF, 3'b100, 3'b000, 3'b101, 11'h001, 11'h000, 11'h0F0, 2'd2, 1);
        step(0, 1, 11'h7FF, 3'b100, 3'b100, 3'b001, 11'h000, 11'h000, 11'h0F0, 2'd1, 1);
        step(0, 0, 11'h000, 3'b000, 3'b000, 3'b010, 11'h000, 11'h0F0, 11'h000, 2'd1, 0);
        @(negedge clk);
        #2;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
